// File: rtl/demux_1n_reg.sv
// Registered 1-to-N demultiplexer: a single-entry buffer steers each word to one of N_CH consumers.
// Optional macro DEMUX_SEL_CHK_EN drops out-of-range selects and raises a sticky err_sel.
module demux_1n_reg #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int MODE = 0,
  localparam int SEL_W = (N_CH < 2) ? 1 : $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [DW-1:0]    in_data,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic [DW-1:0]    out_data,
  output logic             err_sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [SEL_W:0]   N_CH_L  = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t            state_p1;
  logic [N_CH-1:0]   vld_p1;
  logic [DW-1:0]     data_p1;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  dest_sel;
  logic [N_CH-1:0]   dest_oh;
  logic              held_rdy;
  logic              accept;
  logic              keep;

  // Out-of-range selects land on the highest channel.
  function automatic logic [SEL_W-1:0] sat_sel(input logic [SEL_W-1:0] sel);
    if ({1'b0, sel} >= N_CH_L) return LAST_CH;
    return sel;
  endfunction

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] p);
    if (p == LAST_CH) return '0;
    return p + SEL_W'(1);
  endfunction

  // vld_p1 is one-hot on the held channel, so masking out_ready with it ignores the others.
  assign held_rdy = |(out_ready & vld_p1);
  assign in_ready = rst_n && ((state_p1 == EMPTY) || held_rdy);
  assign accept   = in_valid && in_ready;
  assign dest_sel = (MODE == 1) ? rr_ptr : sat_sel(in_sel);

  always_comb begin
    dest_oh = '0;
    for (int i = 0; i < N_CH; i++) begin
      dest_oh[i] = (dest_sel == SEL_W'(i));
    end
  end

`ifdef DEMUX_SEL_CHK_EN
  logic sel_oob;
  logic err_p1;

  assign sel_oob = (MODE == 0) && ({1'b0, in_sel} >= N_CH_L);
  assign keep    = accept && !sel_oob;
  assign err_sel = err_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_p1 <= 1'b0;
    end else if (accept && sel_oob) begin
      err_p1 <= 1'b1;
    end
  end
`else
  assign keep    = accept;
  assign err_sel = 1'b0;
`endif

  // Stage p1: buffer register feeding the output ports
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
      vld_p1   <= '0;
      data_p1  <= '0;
      rr_ptr   <= '0;
    end else begin
      if (keep) begin
        state_p1 <= FULL;
        vld_p1   <= dest_oh;
        data_p1  <= in_data;
      end else if (held_rdy) begin
        state_p1 <= EMPTY;
        vld_p1   <= '0;
      end
      if (accept && (MODE == 1)) begin
        rr_ptr <= wrap_inc(rr_ptr);
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;

endmodule

// File: tb/tb_demux_1n_reg.sv
// Bench for demux_1n_reg: three instances (4ch select, 4ch round-robin, 3ch select) share one stimulus
// and are compared every cycle against a word-level model, plus directed literal checks.
module tb_demux_1n_reg;

`ifdef DEMUX_SEL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_sel;
  logic [7:0] in_data;
  logic [3:0] out_ready;

  logic [3:0] ov0, ov1;
  logic [2:0] ov2;
  logic [7:0] od0, od1, od2;
  logic       ir0, ir1, ir2;
  logic       er0, er1, er2;

  logic [3:0] ov [3];
  logic [7:0] od [3];
  logic       ir [3];
  logic       er [3];

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  int m_full [3];
  int m_ch   [3];
  int m_data [3];
  int m_rr   [3];
  int m_err  [3];

  demux_1n_reg #(.N_CH(4), .DW(8), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_sel(in_sel),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .err_sel(er0));

  demux_1n_reg #(.N_CH(4), .DW(8), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_sel(in_sel),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .err_sel(er1));

  demux_1n_reg #(.N_CH(3), .DW(8), .MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_sel(in_sel),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready[2:0]), .out_data(od2), .err_sel(er2));

  assign ov[0] = ov0;
  assign ov[1] = ov1;
  assign ov[2] = {1'b0, ov2};
  assign od[0] = od0;
  assign od[1] = od1;
  assign od[2] = od2;
  assign ir[0] = ir0;
  assign ir[1] = ir1;
  assign ir[2] = ir2;
  assign er[0] = er0;
  assign er[1] = er1;
  assign er[2] = er2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: the buffer either holds (channel, data) or is empty.
  function automatic int m_valid(input int k);
    return (m_full[k] != 0) ? (1 << m_ch[k]) : 0;
  endfunction

  function automatic bit m_ready(input int k);
    return rst_n && ((m_full[k] == 0) || out_ready[m_ch[k]]);
  endfunction

  function automatic void mstep(input int k, input int n, input int mode);
    bit rdy;
    bit bad;
    int dst;
    if (!rst_n) begin
      m_full[k] = 0; m_data[k] = 0; m_rr[k] = 0; m_err[k] = 0; m_ch[k] = 0;
      return;
    end
    rdy = m_ready(k);
    bad = (mode == 0) && (int'(in_sel) >= n);
    dst = (mode == 1) ? m_rr[k] : (bad ? n - 1 : int'(in_sel));
    if (in_valid && rdy) begin
      if (bad && CHK) begin
        m_err[k]  = 1;
        m_full[k] = 0;
      end else begin
        m_full[k] = 1;
        m_ch[k]   = dst;
        m_data[k] = int'(in_data);
      end
      if (mode == 1) m_rr[k] = (m_rr[k] + 1) % n;
    end else if ((m_full[k] != 0) && out_ready[m_ch[k]]) begin
      m_full[k] = 0;
    end
  endfunction

  always @(posedge clk) begin
    mstep(0, 4, 0);
    mstep(1, 4, 1);
    mstep(2, 3, 0);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("m%0d_valid", k), 64'(ov[k]), 64'(m_valid(k)));
        check($sformatf("m%0d_data", k),  64'(od[k]), 64'(m_data[k]));
        check($sformatf("m%0d_ready", k), 64'(ir[k]), 64'(m_ready(k)));
        check($sformatf("m%0d_err", k),   64'(er[k]), 64'(m_err[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_sels [6];
    rr_sels = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd3};
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    tick();
    chk_on = 1'b1;
    tick();
    check("rst_valid", 64'(ov0), 64'h0);
    check("rst_ready", 64'(ir0), 64'h0);
    check("rst_data",  64'(od0), 64'h0);
    rst_n = 1'b1;
    tick();

    // single word to channel 2, drained immediately
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'b1111;
    tick();
    in_valid = 1'b0;
    check("t35_valid", 64'(ov0), 64'h4);
    check("t35_data",  64'(od0), 64'hA5);
    tick();
    check("t35_empty", 64'(ov0), 64'h0);
    check("t35_hold",  64'(od0), 64'hA5);

    // back-pressure on channel 2, other channel ready ignored
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'b0001;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t36_valid", 64'(ov0), 64'h4);
      check("t36_data",  64'(od0), 64'hA5);
      check("t36_ready", 64'(ir0), 64'h0);
      tick();
    end
    out_ready = 4'b1111;
    #1;
    check("t36_release", 64'(ir0), 64'h1);
    tick();
    check("t36_drained", 64'(ov0), 64'h0);

    // back-to-back stream, no bubble
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i); in_data = 8'(8'h10 + i);
      tick();
      check("t37_valid", 64'(ov0), 64'(1 << i));
      check("t37_data",  64'(od0), 64'(8'h10 + i));
      check("t37_ready", 64'(ir0), 64'h1);
      if (i == 3) begin
        check("t39_valid", 64'(ov2), CHK ? 64'h0 : 64'h4);
        check("t39_err",   64'(er2), 64'(CHK));
      end
    end
    in_valid = 1'b0;
    tick();
    check("t37_empty", 64'(ov0), 64'h0);
    check("t39_sticky", 64'(er2), 64'(CHK));

    // round-robin: channel follows the pointer, not in_sel
    rst_n = 1'b0;
    tick();
    check("t38_rst_err", 64'(er2), 64'h0);
    check("t38_rst_valid", 64'(ov1), 64'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_sel = rr_sels[i]; in_data = 8'(8'h20 + i);
      tick();
      check("t38_valid", 64'(ov1), 64'(1 << (i % 4)));
      check("t38_data",  64'(od1), 64'(8'h20 + i));
    end
    in_valid = 1'b0;
    tick();

    // reset while FULL discards the word
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h5C;
    tick();
    in_valid = 1'b0;
    check("t40_full", 64'(ov0), 64'h2);
    check("t40_fdata", 64'(od0), 64'h5C);
    rst_n = 1'b0;
    #1;
    check("t40_rdy_low", 64'(ir0), 64'h0);
    tick();
    check("t40_valid", 64'(ov0), 64'h0);
    check("t40_data",  64'(od0), 64'h0);
    check("t40_err",   64'(er2), 64'h0);
    check("t40_ready", 64'(ir0), 64'h0);
    rst_n = 1'b1; out_ready = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t40_never", 64'(ov0), 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
